graph_color_solver: RTL and testbench

- Sequential backtracking solver for the map-colouring constraint problem whose combinational validity checker already exists in this codebase.
- Holds a software-loaded edge table, assigns one colour per node and checks one edge per cycle through a single shared comparator.
- Finds the lexicographically first valid colouring, or reports that none exists.
- Sits alongside the checker; the checker can independently validate the coloring output.

---
 rtl/graph_color_pkg.sv | 28 ++
 rtl/graph_color_edge_ram.sv | 28 ++
 rtl/graph_color_solver.sv | 186 ++++++++++++++++++
 tb/tb_graph_color_solver.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_color_pkg.sv
// Shared types and width helpers for the graph colouring solver.
// The optional VERIFY state is only reachable with GRAPH_COLOR_SOLVER_VERIFY_EN.
package graph_color_pkg;

    localparam int DEF_MAX_NODES = 64;
    localparam int DEF_MAX_EDGES = 128;
    localparam int DEF_N_COLORS  = 4;

    // Colour fields are never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CW = min1_clog2(DEF_N_COLORS);

    typedef logic [DEF_CW-1:0] color_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NEXTCOL,
        ADVANCE,
        BACKTRACK,
        VERIFY,
        DONE
    } state_t;

endpackage

// File: rtl/graph_color_edge_ram.sv
// Edge table: one synchronous write port, one combinational read port.
// Out-of-range writes are dropped; out-of-range reads return a (0,0) self-loop.
module graph_color_edge_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 8,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && int'(waddr) < DEPTH) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/graph_color_solver.sv
// Backtracking map-colouring solver, one edge checked per cycle.
// Define GRAPH_COLOR_SOLVER_VERIFY_EN for a final re-check pass and err output.
module graph_color_solver
    import graph_color_pkg::*;
#(
    parameter int MAX_NODES = DEF_MAX_NODES,
    parameter int MAX_EDGES = DEF_MAX_EDGES,
    parameter int N_COLORS  = DEF_N_COLORS,
    localparam int NW = $clog2(MAX_NODES),
    localparam int EW = $clog2(MAX_EDGES + 1),
    localparam int CW = min1_clog2(N_COLORS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [EW-1:0]           cfg_idx,
    input  logic [NW-1:0]           cfg_u,
    input  logic [NW-1:0]           cfg_v,
    input  logic [NW:0]             num_nodes,
    input  logic [EW-1:0]           num_edges,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [MAX_NODES*CW-1:0] coloring
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
    ,
    output logic                    err
`endif
);

    state_t state, nxt;

    logic [NW-1:0]                 node;
    logic [EW-1:0]                 ptr;
    logic [EW-1:0]                 ne;
    logic [NW:0]                   nn;
    logic [MAX_NODES-1:0][CW-1:0]  col;
    logic [2*NW-1:0]               rd;
    logic [NW-1:0]                 eu, ev;
    logic                          conflict;
    logic                          last_edge;
    logic                          last_node;
    logic                          top_col;

    graph_color_edge_ram #(
        .DEPTH (MAX_EDGES),
        .AW    (EW),
        .DW    (2*NW)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we & ~busy),
        .waddr (cfg_idx),
        .wdata ({cfg_u, cfg_v}),
        .raddr (ptr),
        .rdata (rd)
    );

    assign {eu, ev}  = rd;
    assign coloring  = col;
    assign last_edge = (ne == '0) || (ptr == ne - 1'b1);
    assign last_node = ({1'b0, node} == nn - 1'b1);
    assign top_col   = (col[node] == CW'(N_COLORS - 1));

    // Only edges back to already-coloured nodes can conflict.
    assign conflict = (ne != '0) && (
        (eu == node && ev < node && col[ev] == col[node]) ||
        (ev == node && eu < node && col[eu] == col[node]));

`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
    logic bad_edge;
    assign bad_edge = ({1'b0, eu} < nn) && ({1'b0, ev} < nn) &&
                      (eu != ev) && (col[eu] == col[ev]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) nxt = (num_nodes == '0) ? DONE : SCAN;
                else       nxt = IDLE;
            end
            SCAN: begin
                if (conflict)       nxt = NEXTCOL;
                else if (last_edge) nxt = ADVANCE;
            end
            NEXTCOL: nxt = top_col ? BACKTRACK : SCAN;
            ADVANCE: begin
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
                if (last_node) nxt = (ne == '0) ? DONE : VERIFY;
`else
                if (last_node) nxt = DONE;
`endif
                else           nxt = SCAN;
            end
            BACKTRACK: nxt = (node == '0) ? DONE : NEXTCOL;
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
            VERIFY: if (last_edge) nxt = DONE;
`endif
            default: nxt = IDLE;
        endcase
        if (abort && busy) nxt = IDLE;
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SCAN, NEXTCOL, ADVANCE, BACKTRACK, VERIFY: busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node  <= '0;
            ptr   <= '0;
            ne    <= '0;
            nn    <= '0;
            col   <= '0;
            found <= 1'b0;
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
            err   <= 1'b0;
`endif
        end else if (abort && busy) begin
            found <= 1'b0;
            col   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        nn    <= num_nodes;
                        ne    <= num_edges;
                        node  <= '0;
                        ptr   <= '0;
                        col   <= '0;
                        found <= (num_nodes == '0);
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
                        err   <= 1'b0;
`endif
                    end
                end
                SCAN: if (!conflict && !last_edge) ptr <= ptr + 1'b1;
                NEXTCOL: begin
                    if (!top_col) begin
                        col[node] <= col[node] + 1'b1;
                        ptr       <= '0;
                    end
                end
                ADVANCE: begin
                    ptr <= '0;
                    if (last_node) begin
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
                        if (ne == '0) found <= 1'b1;
`else
                        found <= 1'b1;
`endif
                    end else begin
                        node <= node + 1'b1;
                        col[node + 1'b1] <= '0;
                    end
                end
                BACKTRACK: begin
                    col[node] <= '0;
                    if (node != '0) node <= node - 1'b1;
                end
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
                VERIFY: begin
                    ptr <= ptr + 1'b1;
                    if (bad_edge) err <= 1'b1;
                    if (last_edge) found <= !(err || bad_edge);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_color_solver.sv
// Bench for graph_color_solver: 4-colour and 2-colour instances against a
// search model that walks colour choices over an adjacency matrix.
module tb_graph_color_solver;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [7:0]   cfg_idx;
    logic [5:0]   cfg_u, cfg_v;
    logic [6:0]   num_nodes;
    logic [7:0]   num_edges;
    logic         start, abort, start2, abort2;
    logic         busy, done, found;
    logic         busy2, done2, found2;
    logic [127:0] coloring;
    logic [63:0]  coloring2;
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
    logic         err, err2;
`endif

    int checks = 0;
    int failures = 0;

    int  tbl_u [128];
    int  tbl_v [128];
    int  mcol  [64];
    bit  mfound;

    always #5 clk = ~clk;

    graph_color_solver dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_u     (cfg_u),
        .cfg_v     (cfg_v),
        .num_nodes (num_nodes),
        .num_edges (num_edges),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .coloring  (coloring)
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
        ,
        .err       (err)
`endif
    );

    graph_color_solver #(.N_COLORS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_u     (cfg_u),
        .cfg_v     (cfg_v),
        .num_nodes (num_nodes),
        .num_edges (num_edges),
        .start     (start2),
        .abort     (abort2),
        .busy      (busy2),
        .done      (done2),
        .found     (found2),
        .coloring  (coloring2)
`ifdef GRAPH_COLOR_SOLVER_VERIFY_EN
        ,
        .err       (err2)
`endif
    );

    // Lexicographically first colouring: node 0 is the most significant choice.
    task automatic model_solve(input int n, input int m, input int k);
        bit adj [64][64];
        int c [64];
        int i;
        bit ok, fin;
        for (int a = 0; a < 64; a++) begin
            c[a] = 0;
            for (int b = 0; b < 64; b++) adj[a][b] = 0;
        end
        for (int e = 0; e < m; e++) begin
            if (tbl_u[e] != tbl_v[e] && tbl_u[e] < n && tbl_v[e] < n) begin
                adj[tbl_u[e]][tbl_v[e]] = 1;
                adj[tbl_v[e]][tbl_u[e]] = 1;
            end
        end
        mfound = (n == 0);
        fin = (n == 0);
        i = 0;
        while (!fin) begin
            ok = 0;
            while (!ok && c[i] < k) begin
                ok = 1;
                for (int j = 0; j < i; j++)
                    if (adj[i][j] && c[j] == c[i]) ok = 0;
                if (!ok) c[i]++;
            end
            if (ok) begin
                if (i == n - 1) begin
                    mfound = 1;
                    fin = 1;
                end else begin
                    i++;
                    c[i] = 0;
                end
            end else begin
                c[i] = 0;
                if (i == 0) fin = 1;
                else begin
                    i--;
                    c[i]++;
                end
            end
        end
        for (int a = 0; a < 64; a++) mcol[a] = c[a];
    endtask

    function automatic logic [127:0] exp4();
        logic [127:0] r;
        int x;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            x = mcol[i];
            r[i*2 +: 2] = x[1:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp2();
        logic [63:0] r;
        int x;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            x = mcol[i];
            r[i] = x[0];
        end
        return r;
    endfunction

    task automatic write_edge(input int idx, input int u, input int v);
        cfg_we  = 1'b1;
        cfg_idx = idx[7:0];
        cfg_u   = u[5:0];
        cfg_v   = v[5:0];
        @(negedge clk);
        cfg_we  = 1'b0;
        if (idx < 128) begin
            tbl_u[idx] = u;
            tbl_v[idx] = v;
        end
    endtask

    task automatic load_k5();
        int s;
        s = 0;
        for (int a = 0; a < 5; a++)
            for (int b = a + 1; b < 5; b++) begin
                write_edge(s, a, b);
                s++;
            end
    endtask

    task automatic pulse_start(input int which, input int n, input int m);
        num_nodes = n[6:0];
        num_edges = m[7:0];
        if (which == 0) start = 1'b1;
        else            start2 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget,
                             output int cyc, output bit hit);
        hit = 0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            cyc++;
            if ((which == 0) ? done : done2) hit = 1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_we = 0; cfg_idx = 0; cfg_u = 0; cfg_v = 0;
        num_nodes = 0; num_edges = 0;
        start = 0; abort = 0; start2 = 0; abort2 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, found} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, found});
        end
        checks++;
        if (coloring !== '0 || coloring2 !== '0) begin
            failures++;
            $display("FAIL reset_coloring got=%h/%h want=0", coloring, coloring2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_triangle();
        int cyc;
        bit hit;
        write_edge(0, 0, 1);
        write_edge(1, 1, 2);
        write_edge(2, 0, 2);
        model_solve(3, 3, 4);
        pulse_start(0, 3, 3);
        wait_done(0, 5000, cyc, hit);
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL triangle_timeout cycles=%0d", cyc);
        end
        checks++;
        if (found !== 1'b1 || coloring !== exp4()) begin
            failures++;
            $display("FAIL triangle_result found=%b col=%h want=1 col=%h",
                     found, coloring, exp4());
        end
        checks++;
        if (coloring[5:0] !== 6'b100100) begin
            failures++;
            $display("FAIL triangle_colors got=%b want=100100", coloring[5:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || found !== 1'b1) begin
            failures++;
            $display("FAIL triangle_pulse done=%b found=%b want done=0 found=1",
                     done, found);
        end
    endtask

    task automatic test_k5();
        int cyc;
        bit hit;
        load_k5();
        model_solve(5, 10, 4);
        pulse_start(0, 5, 10);
        wait_done(0, 20000, cyc, hit);
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL k5_timeout cycles=%0d", cyc);
        end
        checks++;
        if (found !== mfound || found !== 1'b0 || coloring !== '0) begin
            failures++;
            $display("FAIL k5_result found=%b col=%h want found=0 col=0",
                     found, coloring);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL k5_busy got=%b want=0 at done", busy);
        end
    endtask

    task automatic test_empty();
        int cyc;
        bit hit;
        pulse_start(0, 4, 0);
        wait_done(0, 10, cyc, hit);
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL empty_latency cycles=%0d want<=10", cyc);
        end
        checks++;
        if (found !== 1'b1 || coloring !== '0) begin
            failures++;
            $display("FAIL empty_result found=%b col=%h want found=1 col=0",
                     found, coloring);
        end
        @(negedge clk);
        pulse_start(0, 0, 0);
        wait_done(0, 1, cyc, hit);
        checks++;
        if (!hit || found !== 1'b1) begin
            failures++;
            $display("FAIL zero_nodes hit=%b found=%b want hit=1 found=1",
                     hit, found);
        end
    endtask

    task automatic test_two_color();
        int cyc;
        bit hit;
        write_edge(0, 0, 1);
        write_edge(1, 1, 2);
        pulse_start(1, 3, 2);
        wait_done(1, 5000, cyc, hit);
        model_solve(3, 2, 2);
        checks++;
        if (!hit || found2 !== 1'b1 || coloring2[2:0] !== 3'b010 ||
            coloring2 !== exp2()) begin
            failures++;
            $display("FAIL path2 hit=%b found=%b col=%h want found=1 col=%h",
                     hit, found2, coloring2, exp2());
        end
        @(negedge clk);
        write_edge(2, 0, 2);
        pulse_start(1, 3, 3);
        wait_done(1, 5000, cyc, hit);
        checks++;
        if (!hit || found2 !== 1'b0 || coloring2 !== '0) begin
            failures++;
            $display("FAIL tri2 hit=%b found=%b col=%h want found=0 col=0",
                     hit, found2, coloring2);
        end
    endtask

    task automatic test_abort();
        int cyc, nd;
        bit hit;
        logic [127:0] held;
        @(negedge clk);
        load_k5();
        pulse_start(0, 5, 10);
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre busy=%b want=1", busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || found !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%b found=%b want 0 0", busy, found);
        end
        nd = 0;
        repeat (30) begin
            if (done) nd++;
            @(negedge clk);
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL abort_nodone pulses=%0d want=0", nd);
        end
        model_solve(3, 10, 4);
        pulse_start(0, 3, 10);
        wait_done(0, 5000, cyc, hit);
        @(negedge clk);
        held = coloring;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (found !== 1'b1 || coloring !== exp4() || coloring !== held) begin
            failures++;
            $display("FAIL abort_in_idle found=%b col=%h want found=1 col=%h",
                     found, coloring, exp4());
        end
    endtask

    task automatic test_busy_ignored();
        int cyc;
        bit hit;
        model_solve(3, 10, 4);
        pulse_start(0, 3, 10);
        cfg_we = 1'b1; cfg_idx = 0; cfg_u = 5; cfg_v = 5;
        num_nodes = 2;
        start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        start = 1'b0;
        wait_done(0, 5000, cyc, hit);
        checks++;
        if (!hit || found !== 1'b1 || coloring !== exp4()) begin
            failures++;
            $display("FAIL busy_start hit=%b found=%b col=%h want col=%h",
                     hit, found, coloring, exp4());
        end
        @(negedge clk);
        write_edge(128, 5, 5);
        pulse_start(0, 3, 10);
        wait_done(0, 5000, cyc, hit);
        checks++;
        if (!hit || found !== 1'b1 || coloring !== exp4()) begin
            failures++;
            $display("FAIL busy_cfg_table hit=%b col=%h want col=%h",
                     hit, coloring, exp4());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pulse_start(0, 5, 10);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || found !== 1'b0 || coloring !== '0) begin
            failures++;
            $display("FAIL reset_mid busy=%b found=%b col=%h want 0 0 0",
                     busy, found, coloring);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int n, m, cyc;
        bit hit;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(3, 7);
            m = $urandom_range(0, 12);
            for (int e = 0; e < m; e++)
                write_edge(e, $urandom_range(0, n), $urandom_range(0, n));
            model_solve(n, m, 4);
            pulse_start(0, n, m);
            wait_done(0, 20000, cyc, hit);
            checks++;
            if (!hit || found !== mfound || coloring !== exp4()) begin
                failures++;
                $display("FAIL rand4_%0d n=%0d m=%0d found=%b col=%h want %b %h",
                         it, n, m, found, coloring, mfound, exp4());
            end
            @(negedge clk);
            model_solve(n, m, 2);
            pulse_start(1, n, m);
            wait_done(1, 20000, cyc, hit);
            checks++;
            if (!hit || found2 !== mfound || coloring2 !== exp2()) begin
                failures++;
                $display("FAIL rand2_%0d n=%0d m=%0d found=%b col=%h want %b %h",
                         it, n, m, found2, coloring2, mfound, exp2());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_map48();
        int s, cyc, bad, cu, cv;
        bit hit;
        s = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                write_edge(s, r*8 + c, r*8 + c + 1);
                s++;
            end
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 8; c++) begin
                write_edge(s, r*8 + c, (r+1)*8 + c);
                s++;
            end
        for (int d = 0; d < 17; d++) begin
            write_edge(s, (d/7)*8 + d%7, (d/7 + 1)*8 + d%7 + 1);
            s++;
        end
        model_solve(48, 99, 4);
        pulse_start(0, 48, 99);
        wait_done(0, 40000, cyc, hit);
        checks++;
        if (!hit || found !== 1'b1 || coloring !== exp4()) begin
            failures++;
            $display("FAIL map48 hit=%b found=%b col=%h want found=1 col=%h",
                     hit, found, coloring, exp4());
        end
        bad = 0;
        for (int e = 0; e < 99; e++) begin
            cu = int'(coloring[tbl_u[e]*2 +: 2]);
            cv = int'(coloring[tbl_v[e]*2 +: 2]);
            if (cu == cv) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL map48_valid bad_edges=%0d want=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_k5();
        @(negedge clk);
        test_empty();
        @(negedge clk);
        test_two_color();
        test_abort();
        test_busy_ignored();
        test_reset_mid();
        test_random();
        test_map48();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
